// File: rtl/control_ajuste_hora_pkg.sv
// Shared encodings and default limits for the time-setting controller.
package control_ajuste_hora_pkg;

    localparam int MAX_HORA_DEF   = 23;
    localparam int MAX_MINSEG_DEF = 59;
    localparam int HORA_W         = 5;
    localparam int MINSEG_W       = 6;

    // State encoding doubles as the campo_activo output code.
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        EDIT_HORA = 2'b01,
        EDIT_MIN  = 2'b10,
        EDIT_SEG  = 2'b11
    } estado_t;

    // Field rotation used by the siguiente button while editing.
    function automatic estado_t campo_siguiente(input estado_t e);
        case (e)
            EDIT_HORA: campo_siguiente = EDIT_MIN;
            EDIT_MIN:  campo_siguiente = EDIT_SEG;
            default:   campo_siguiente = EDIT_HORA;
        endcase
    endfunction

endpackage

// File: rtl/control_ajuste_hora_contador.sv
// Modular up/down counter 0..MAX with wrap-around and a combinational carry.
module contador_modular #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clear,
    output logic [W-1:0] valor,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Carry fires in the same cycle an increment wraps MAX -> 0.
    assign carry = inc && !dec && (valor == MAX_V);

    // Counter register; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valor <= '0;
        else if (clear)
            valor <= '0;
        else if (inc && !dec)
            valor <= (valor == MAX_V) ? '0 : valor + W'(1);
        else if (dec && !inc)
            valor <= (valor == '0) ? MAX_V : valor - W'(1);
    end

endmodule

// File: rtl/control_ajuste_hora.sv
// Clock time keeper with a button-driven edit mode (hours/minutes/seconds).
module control_ajuste_hora
    import control_ajuste_hora_pkg::*;
#(
    parameter int MAX_HORA   = MAX_HORA_DEF,
    parameter int MAX_MINSEG = MAX_MINSEG_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_1hz,
    input  logic                modo_config,
    input  logic                aumentar,
    input  logic                disminuir,
    input  logic                siguiente,
    output logic [HORA_W-1:0]   horas,
    output logic [MINSEG_W-1:0] minutos,
    output logic [MINSEG_W-1:0] segundos,
    output logic [1:0]          campo_activo,
    output logic                escribir
);

    estado_t estado, estado_n;
    logic    escribir_n;
    logic    en_run;
    logic    inc_s, dec_s, inc_m, dec_m, inc_h, dec_h;
    logic    carry_s, carry_m, carry_h_unused;

    assign en_run = (estado == RUN);

    // In RUN the counters form a carry chain driven by the 1 Hz tick;
    // in edit only the selected field sees the buttons and carries stay local.
    assign inc_s = en_run ? tick_1hz : (estado == EDIT_SEG) && aumentar;
    assign dec_s = !en_run && (estado == EDIT_SEG) && disminuir;
    assign inc_m = en_run ? carry_s  : (estado == EDIT_MIN) && aumentar;
    assign dec_m = !en_run && (estado == EDIT_MIN) && disminuir;
    assign inc_h = en_run ? carry_m  : (estado == EDIT_HORA) && aumentar;
    assign dec_h = !en_run && (estado == EDIT_HORA) && disminuir;

    contador_modular #(.MAX(MAX_MINSEG), .W(MINSEG_W)) u_seg (
        .clk(clk), .reset_n(reset_n), .inc(inc_s), .dec(dec_s), .clear(1'b0),
        .valor(segundos), .carry(carry_s)
    );

    contador_modular #(.MAX(MAX_MINSEG), .W(MINSEG_W)) u_min (
        .clk(clk), .reset_n(reset_n), .inc(inc_m), .dec(dec_m), .clear(1'b0),
        .valor(minutos), .carry(carry_m)
    );

    contador_modular #(.MAX(MAX_HORA), .W(HORA_W)) u_hora (
        .clk(clk), .reset_n(reset_n), .inc(inc_h), .dec(dec_h), .clear(1'b0),
        .valor(horas), .carry(carry_h_unused)
    );

    // State and commit strobe registers; reset drops any open edit silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= RUN;
            escribir <= 1'b0;
        end else begin
            estado   <= estado_n;
            escribir <= escribir_n;
        end
    end

    // Next-state: leaving edit has priority over field rotation.
    always_comb begin
        estado_n   = estado;
        escribir_n = 1'b0;
        case (estado)
            RUN: begin
                if (modo_config)
                    estado_n = EDIT_HORA;
            end
            default: begin
                if (!modo_config) begin
                    estado_n   = RUN;
                    escribir_n = 1'b1;
                end else if (siguiente) begin
                    estado_n = campo_siguiente(estado);
                end
            end
        endcase
    end

    assign campo_activo = estado;

endmodule

// File: tb/tb_control_ajuste_hora.sv
// Self-checking bench: directed scenarios plus random traffic against a
// time-in-seconds reference model.
module tb_control_ajuste_hora;

    localparam int MH = 23;
    localparam int MS = 59;

    logic       clk = 1'b0;
    logic       reset_n, tick_1hz, modo_config, aumentar, disminuir, siguiente;
    logic [4:0] horas;
    logic [5:0] minutos, segundos;
    logic [1:0] campo_activo;
    logic       escribir;

    int vectors = 0;
    int miscompares = 0;

    // reference model: field 0 = none, 1 = hours, 2 = minutes, 3 = seconds
    int m_h, m_m, m_s, m_f;
    bit m_w;

    control_ajuste_hora #(.MAX_HORA(MH), .MAX_MINSEG(MS)) dut (
        .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .modo_config(modo_config),
        .aumentar(aumentar), .disminuir(disminuir), .siguiente(siguiente),
        .horas(horas), .minutos(minutos), .segundos(segundos),
        .campo_activo(campo_activo), .escribir(escribir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        vectors++;
        assert (got === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".horas"},    32'(horas),        m_h);
        check({tag, ".minutos"},  32'(minutos),      m_m);
        check({tag, ".segundos"}, 32'(segundos),     m_s);
        check({tag, ".campo"},    32'(campo_activo), m_f);
        check({tag, ".escribir"}, 32'(escribir),     int'(m_w));
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_f = 0; m_w = 0;
    endtask

    task automatic model_step(input bit tk, input bit mc, input bit au, input bit di, input bit si);
        bit up, dn;
        int t;
        up  = au && !di;
        dn  = di && !au;
        m_w = (m_f != 0) && !mc;
        if (m_f == 0) begin
            if (tk) begin
                t   = (m_h * (MS + 1) + m_m) * (MS + 1) + m_s;
                t   = (t + 1) % ((MH + 1) * (MS + 1) * (MS + 1));
                m_s = t % (MS + 1);
                m_m = (t / (MS + 1)) % (MS + 1);
                m_h = t / ((MS + 1) * (MS + 1));
            end
        end else begin
            case (m_f)
                1: begin if (up) m_h = (m_h + 1) % (MH + 1); if (dn) m_h = (m_h + MH) % (MH + 1); end
                2: begin if (up) m_m = (m_m + 1) % (MS + 1); if (dn) m_m = (m_m + MS) % (MS + 1); end
                default: begin if (up) m_s = (m_s + 1) % (MS + 1); if (dn) m_s = (m_s + MS) % (MS + 1); end
            endcase
        end
        if (m_f == 0)     m_f = mc ? 1 : 0;
        else if (!mc)     m_f = 0;
        else if (si)      m_f = (m_f == 3) ? 1 : m_f + 1;
    endtask

    // Apply one cycle of inputs (called 1 time unit after a rising edge).
    task automatic step(input bit tk, input bit mc, input bit au, input bit di, input bit si,
                        input string tag);
        tick_1hz = tk; modo_config = mc; aumentar = au; disminuir = di; siguiente = si;
        @(posedge clk);
        #1;
        model_step(tk, mc, au, di, si);
        check_all(tag);
    endtask

    initial begin
        bit mc_lvl;
        reset_n = 1'b0; tick_1hz = 0; modo_config = 0; aumentar = 0; disminuir = 0; siguiente = 0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 61 ticks in RUN
        for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0, "run_tick");
        check("t61_h", 32'(horas), 0);
        check("t61_m", 32'(minutos), 1);
        check("t61_s", 32'(segundos), 1);
        check("t61_campo", 32'(campo_activo), 0);

        // buttons ignored in RUN
        step(0, 0, 1, 0, 0, "run_aum");
        step(0, 0, 0, 1, 1, "run_dis_sig");

        // preset 23:59:59 through edit mode
        step(0, 1, 0, 0, 0, "enter");
        step(0, 1, 0, 1, 0, "h_dec");
        step(0, 1, 0, 0, 1, "to_min");
        step(0, 1, 0, 1, 0, "m_dec");
        step(0, 1, 0, 1, 0, "m_dec");
        step(0, 1, 0, 0, 1, "to_seg");
        step(0, 1, 0, 1, 0, "s_dec");
        step(0, 1, 0, 1, 0, "s_dec");
        check("preset_h", 32'(horas), 23);
        check("preset_m", 32'(minutos), 59);
        check("preset_s", 32'(segundos), 59);
        step(0, 0, 0, 0, 0, "exit");
        check("exit_escribir", 32'(escribir), 1);
        step(1, 0, 0, 0, 0, "day_wrap");
        check("wrap_h", 32'(horas), 0);
        check("wrap_m", 32'(minutos), 0);
        check("wrap_s", 32'(segundos), 0);
        check("wrap_escribir", 32'(escribir), 0);

        // hours down-wrap, minute up-wrap without carry
        step(0, 1, 0, 0, 0, "enter2");
        step(0, 1, 0, 1, 0, "h_dec");
        step(0, 1, 0, 1, 0, "h_dec");
        check("h22", 32'(horas), 22);
        step(0, 1, 0, 0, 1, "to_min2");
        check("campo_min", 32'(campo_activo), 2);
        step(0, 1, 0, 1, 0, "m_to59");
        step(0, 1, 1, 0, 0, "m_wrap");
        check("m_wrap_m", 32'(minutos), 0);
        check("m_wrap_h", 32'(horas), 22);

        // simultaneous buttons
        step(0, 1, 1, 1, 0, "aum_dis");
        check("aum_dis_m", 32'(minutos), 0);
        step(0, 1, 1, 0, 1, "aum_sig");
        check("aum_sig_m", 32'(minutos), 1);
        check("aum_sig_campo", 32'(campo_activo), 3);

        // time frozen in edit, then commit and resume
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, "frozen");
        check("frozen_s", 32'(segundos), 0);
        step(0, 0, 0, 0, 0, "commit");
        check("commit_escribir", 32'(escribir), 1);
        step(1, 0, 0, 0, 0, "resume");
        check("resume_s", 32'(segundos), 1);
        check("resume_escribir", 32'(escribir), 0);

        // adjust in the same cycle as leaving edit still applies
        step(0, 1, 0, 0, 0, "enter3");
        step(0, 0, 1, 0, 0, "adj_exit");
        check("adj_exit_h", 32'(horas), 23);

        // asynchronous reset in the middle of an edit
        step(0, 1, 0, 0, 0, "enter4");
        step(0, 1, 1, 0, 1, "edit4");
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk); #1;
        check_all("reset_hold");
        reset_n = 1'b1;
        modo_config = 1'b0;
        step(1, 0, 0, 0, 0, "post_reset");

        // random traffic
        mc_lvl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) mc_lvl = !mc_lvl;
            step(bit'($urandom_range(1)), mc_lvl,
                 $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
